// File: rtl/forward_operand_datapath.sv
// Operand-forwarding datapath: builds ALU operands from rf/EX/DM/WB sources,
// drives the data-memory port and carries results through EX -> DM -> WB.
module forward_operand_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic [1:0]        mux_sel_A,
    input  logic [1:0]        mux_sel_B,
    input  logic [7:0]        imm,
    input  logic              imm_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_mux_sel_dm,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic              we_dm,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] dm_result;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] store_data_q;
    logic [DATA_W-1:0] ex_result_q;
    wb_t               wb_q;

    // imm is zero-extended on wide datapaths and truncated on narrow ones
    generate
        if (DATA_W > 8) begin : g_imm_wide
            assign imm_ext = {{(DATA_W-8){1'b0}}, imm};
        end else if (DATA_W == 8) begin : g_imm_eq
            assign imm_ext = imm;
        end else begin : g_imm_narrow
            assign imm_ext = imm[DATA_W-1:0];
        end
    endgenerate

    assign dm_result = mem_mux_sel_dm ? mem_rdata : ex_result_q;

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] ex,
        input logic [DATA_W-1:0] dm,
        input logic [DATA_W-1:0] wb
    );
        case (sel)
            2'b00:   return rf;
            2'b01:   return ex;
            2'b10:   return dm;
            default: return wb;
        endcase
    endfunction

    assign fwd_a = fwd_mux(mux_sel_A, rf_data_a, alu_result, dm_result, wb_q.data);
    assign fwd_b = fwd_mux(mux_sel_B, rf_data_b, alu_result, dm_result, wb_q.data);

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            store_data_q <= '0;
            ex_result_q  <= '0;
            wb_q         <= '0;
        end else if (!stall) begin
            alu_a_q      <= fwd_a;
            alu_b_q      <= imm_sel ? imm_ext : fwd_b;
            // store data ignores imm_sel: stores use the immediate as offset only
            store_data_q <= fwd_b;
            ex_result_q  <= alu_result;
            wb_q.en      <= we_dm;
            wb_q.addr    <= RW_dm;
            wb_q.data    <= dm_result;
        end
    end

    // a stalled cycle must not repeat the access already issued for this op
    assign mem_en     = mem_en_ex & ~stall;
    assign mem_rw     = mem_rw_ex;
    assign mem_addr   = alu_result;
    assign mem_wdata  = store_data_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rf_wr_en   = wb_q.en;
    assign rf_wr_addr = wb_q.addr;
    assign rf_wr_data = wb_q.data;

endmodule

// File: tb/tb_forward_operand_datapath.sv
// Scoreboard bench: stimulus queues expected output values tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_forward_operand_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    localparam int O_ALU_A = 0, O_ALU_B = 1, O_WDATA = 2, O_WEN = 3,
                   O_WADDR = 4, O_WDATA_RF = 5, O_MEM_EN = 6, O_MEM_ADDR = 7,
                   O_MEM_RW = 8;

    logic              clk = 1'b0;
    logic              reset, stall;
    logic [DATA_W-1:0] rf_data_a, rf_data_b;
    logic [1:0]        mux_sel_A, mux_sel_B;
    logic [7:0]        imm;
    logic              imm_sel;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              mem_en_ex, mem_rw_ex, mem_en, mem_rw;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              mem_mux_sel_dm;
    logic [ADDR_W-1:0] RW_dm;
    logic              we_dm, rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    forward_operand_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .imm(imm), .imm_sel(imm_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_mux_sel_dm(mem_mux_sel_dm), .RW_dm(RW_dm), .we_dm(we_dm),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            O_ALU_A:    return 32'(alu_a);
            O_ALU_B:    return 32'(alu_b);
            O_WDATA:    return 32'(mem_wdata);
            O_WEN:      return 32'(rf_wr_en);
            O_WADDR:    return 32'(rf_wr_addr);
            O_WDATA_RF: return 32'(rf_wr_data);
            O_MEM_EN:   return 32'(mem_en);
            O_MEM_ADDR: return 32'(mem_addr);
            default:    return 32'(mem_rw);
        endcase
    endfunction

    // monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                checks++;
                if (q[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", q[i].name, q[i].cyc);
                end else if (actual(q[i].sel) !== q[i].val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                             q[i].name, cyc, actual(q[i].sel), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_out(input int dc, input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc + dc; e.name = name; e.sel = sel; e.val = val;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rebuild EX/DM/WB state: alu_result=A1, ex_result_q=B2, rf_wr_data=C3
    task automatic fill_pipe();
        mem_mux_sel_dm = 1'b0; we_dm = 1'b0;
        alu_result = 8'hC3; step();
        alu_result = 8'hB2; step();
        alu_result = 8'hA1;
    endtask

    task automatic fwd_round(input logic [1:0] sa, input logic [1:0] sb,
                             input logic [7:0] ea, input logic [7:0] eb);
        fill_pipe();
        mux_sel_A = sa; mux_sel_B = sb; imm_sel = 1'b0;
        expect_out(0, "fwd_mem_addr", O_MEM_ADDR, 32'hA1);
        expect_out(1, $sformatf("fwd_a_sel%0d", sa), O_ALU_A, 32'(ea));
        expect_out(1, $sformatf("fwd_b_sel%0d", sb), O_ALU_B, 32'(eb));
        expect_out(1, $sformatf("fwd_wdata_sel%0d", sb), O_WDATA, 32'(eb));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // reset with every input nonzero; stall=1 also shows reset wins over stall
        reset = 1; stall = 1;
        rf_data_a = 8'hFF; rf_data_b = 8'hEE; mux_sel_A = 2'b11; mux_sel_B = 2'b01;
        imm = 8'h5A; imm_sel = 1; alu_result = 8'h99; mem_en_ex = 1; mem_rw_ex = 1;
        mem_rdata = 8'h77; mem_mux_sel_dm = 1; RW_dm = 5'd31; we_dm = 1;
        step(); step();
        expect_out(0, "rst_alu_a", O_ALU_A, 0);
        expect_out(0, "rst_alu_b", O_ALU_B, 0);
        expect_out(0, "rst_wdata", O_WDATA, 0);
        expect_out(0, "rst_wr_en", O_WEN, 0);
        expect_out(0, "rst_wr_addr", O_WADDR, 0);
        expect_out(0, "rst_wr_data", O_WDATA_RF, 0);
        expect_out(0, "rst_mem_en", O_MEM_EN, 0);
        @(negedge clk); #1;

        reset = 0; stall = 0; mem_en_ex = 0; mem_rw_ex = 0; we_dm = 0;
        mem_mux_sel_dm = 0; RW_dm = 0; mem_rdata = 0; alu_result = 0; imm = 0;
        step();

        // plain operands, then immediate on B
        rf_data_a = 8'h12; rf_data_b = 8'h34; mux_sel_A = 0; mux_sel_B = 0; imm_sel = 0;
        expect_out(1, "plain_a", O_ALU_A, 32'h12);
        expect_out(1, "plain_b", O_ALU_B, 32'h34);
        step();
        imm = 8'h7F; imm_sel = 1;
        expect_out(1, "imm_b", O_ALU_B, 32'h7F);
        expect_out(1, "imm_wdata", O_WDATA, 32'h34);
        expect_out(1, "imm_a", O_ALU_A, 32'h12);
        step();

        // forwarding sources for both operands
        fwd_round(2'b01, 2'b10, 8'hA1, 8'hB2);
        fwd_round(2'b10, 2'b11, 8'hB2, 8'hC3);
        fwd_round(2'b11, 2'b01, 8'hC3, 8'hA1);

        // load forward: issue read, then forward and write back mem_rdata
        mux_sel_A = 0; mux_sel_B = 0;
        mem_en_ex = 1; mem_rw_ex = 0; alu_result = 8'h20;
        expect_out(0, "ld_mem_en", O_MEM_EN, 1);
        expect_out(0, "ld_mem_rw", O_MEM_RW, 0);
        expect_out(0, "ld_mem_addr", O_MEM_ADDR, 32'h20);
        step();
        mem_en_ex = 0; mem_rdata = 8'h5E; mem_mux_sel_dm = 1; RW_dm = 5'd7; we_dm = 1;
        mux_sel_A = 2'b10;
        expect_out(1, "ld_fwd_a", O_ALU_A, 32'h5E);
        expect_out(1, "ld_wr_en", O_WEN, 1);
        expect_out(1, "ld_wr_addr", O_WADDR, 7);
        expect_out(1, "ld_wr_data", O_WDATA_RF, 32'h5E);
        step();

        // stall: load state, freeze for 3 cycles while inputs change
        mux_sel_A = 0; mux_sel_B = 0; imm_sel = 0; mem_mux_sel_dm = 0;
        rf_data_a = 8'h11; rf_data_b = 8'h22; alu_result = 8'h33;
        we_dm = 1; RW_dm = 5'd3; mem_en_ex = 1; mem_rw_ex = 1;
        step();
        stall = 1; rf_data_a = 8'h44; rf_data_b = 8'h55; alu_result = 8'h66;
        RW_dm = 5'd9; we_dm = 0;
        for (int i = 0; i < 3; i++) begin
            expect_out(0, "stall_mem_en", O_MEM_EN, 0);
            expect_out(1, "stall_alu_a", O_ALU_A, 32'h11);
            expect_out(1, "stall_alu_b", O_ALU_B, 32'h22);
            expect_out(1, "stall_wdata", O_WDATA, 32'h22);
            expect_out(1, "stall_wr_en", O_WEN, 1);
            expect_out(1, "stall_wr_addr", O_WADDR, 3);
            expect_out(1, "stall_wr_data", O_WDATA_RF, 32'h20);
            step();
        end
        stall = 0; mux_sel_A = 2'b10; mux_sel_B = 2'b11; RW_dm = 5'd9; we_dm = 1;
        expect_out(0, "resume_mem_en", O_MEM_EN, 1);
        expect_out(1, "resume_fwd_a", O_ALU_A, 32'h33);
        expect_out(1, "resume_fwd_b", O_ALU_B, 32'h20);
        expect_out(1, "resume_wr_en", O_WEN, 1);
        expect_out(1, "resume_wr_addr", O_WADDR, 9);
        expect_out(1, "resume_wr_data", O_WDATA_RF, 32'h33);
        step();
        we_dm = 0; mux_sel_A = 0; mux_sel_B = 0; mem_en_ex = 0;
        expect_out(1, "resume_next_data", O_WDATA_RF, 32'h66);
        expect_out(1, "resume_next_en", O_WEN, 0);
        step();

        // reset mid-pipeline with a store in EX and a write in DM
        mem_en_ex = 1; mem_rw_ex = 1; alu_result = 8'h77; we_dm = 1; RW_dm = 5'd5;
        rf_data_a = 8'hAA;
        expect_out(1, "pre_rst_wr_en", O_WEN, 1);
        step();
        reset = 1;
        expect_out(1, "mid_rst_wr_en", O_WEN, 0);
        expect_out(1, "mid_rst_wr_data", O_WDATA_RF, 0);
        expect_out(1, "mid_rst_alu_a", O_ALU_A, 0);
        step();
        reset = 0; we_dm = 0; mem_en_ex = 0; mux_sel_A = 2'b10; mem_mux_sel_dm = 0;
        expect_out(1, "flush_ex_q", O_ALU_A, 0);
        expect_out(1, "flush_wr_data", O_WDATA_RF, 0);
        expect_out(1, "flush_wr_en", O_WEN, 0);
        step();
        step(); step();

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
